// File: rtl/vdp_pkg.sv
// Shared VDP constants: status bit layout, register indices, enable bit positions
// and default frame geometry, plus the status-byte packing helper.
package vdp_pkg;

  localparam int STAT_F   = 7;
  localparam int STAT_OVR = 6;
  localparam int STAT_COL = 5;

  localparam int REG_MODE1   = 0;
  localparam int REG_MODE2   = 1;
  localparam int REG_LINECNT = 10;

  localparam int LINE_IE_BIT  = 4;
  localparam int FRAME_IE_BIT = 5;

  localparam int DEF_ACTIVE_LINES = 192;
  localparam int DEF_TOTAL_LINES  = 262;

  typedef struct packed {
    logic f;
    logic ovr;
    logic col;
  } vdp_flags_t;

  function automatic logic [7:0] pack_status(input vdp_flags_t fl);
    logic [7:0] s;
    s           = 8'h00;
    s[STAT_F]   = fl.f;
    s[STAT_OVR] = fl.ovr;
    s[STAT_COL] = fl.col;
    return s;
  endfunction

endpackage

// File: rtl/vdp_line_counter.sv
// 8-bit line-interrupt down-counter: decrements on active lines, reloads on
// underflow and on every line past the active area.
module vdp_line_counter
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_L,
  input  logic       tick,
  input  logic       active,
  input  logic [7:0] reload,
  output logic       uflow
);

  logic [7:0] cnt_q, cnt_d;

  // A zero count never decrements; it reloads and reports the underflow instead.
  assign uflow = tick & active & (cnt_q == 8'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      if (!active || cnt_q == 8'd0) cnt_d = reload;
      else                          cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) cnt_q <= 8'hFF;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vdp_irq_ctrl.sv
// VDP interrupt/status stage: frame, sprite and line flags, status byte, INT_L.
// Build option VDP_IRQ_VECTOR_EN adds the Z80 interrupt-acknowledge response.
module vdp_irq_ctrl
  import vdp_pkg::*;
#(
  parameter int ACTIVE_LINES = DEF_ACTIVE_LINES,
  parameter int TOTAL_LINES  = DEF_TOTAL_LINES,
  parameter int LINE_W       = 9
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              line_tick,
  input  logic [LINE_W-1:0] line_num,
  input  logic              line_ie,
  input  logic              frame_ie,
  input  logic [7:0]        line_reload,
  input  logic              spr_ovf,
  input  logic              spr_col,
  input  logic              stat_rd,
`ifdef VDP_IRQ_VECTOR_EN
  input  logic              M1_L,
  input  logic              IORQ_L,
  output logic [7:0]        vec_out,
  output logic              vec_oe,
`endif
  output logic [7:0]        stat_reg_out,
  output logic              line_pend,
  output logic              INT_L
);

  vdp_flags_t flags_q, flags_d;
  logic       pend_q, pend_d;
  logic       int_l_q, int_l_d;
  logic       tick_ok, line_active, frame_set, line_uflow, ack_clr;

  // Ticks outside the frame are dropped before reaching any state.
  assign tick_ok     = line_tick & ({1'b0, line_num} < (LINE_W+1)'(TOTAL_LINES));
  assign line_active = line_num <= LINE_W'(ACTIVE_LINES);
  assign frame_set   = tick_ok & (line_num == LINE_W'(ACTIVE_LINES));

  vdp_line_counter u_line_counter (
    .clk    (clk),
    .rst_L  (rst_L),
    .tick   (tick_ok),
    .active (line_active),
    .reload (line_reload),
    .uflow  (line_uflow)
  );

`ifdef VDP_IRQ_VECTOR_EN
  logic ack_now, ack_q;

  assign ack_now = ~M1_L & ~IORQ_L & ~int_l_q;
  assign vec_oe  = ack_now;
  assign vec_out = ack_now ? 8'hFF : 8'h00;
  // The pending line interrupt is consumed when the acknowledge cycle ends.
  assign ack_clr = ack_q & (M1_L | IORQ_L);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) ack_q <= 1'b0;
    else        ack_q <= ack_now;
  end
`else
  assign ack_clr = 1'b0;
`endif

  // Set events win over a simultaneous status read, flag by flag.
  always_comb begin
    flags_d.f   = frame_set | (flags_q.f   & ~stat_rd);
    flags_d.ovr = spr_ovf   | (flags_q.ovr & ~stat_rd);
    flags_d.col = spr_col   | (flags_q.col & ~stat_rd);
    pend_d      = line_uflow | (pend_q & ~stat_rd & ~ack_clr);
    int_l_d     = ~((flags_q.f & frame_ie) | (pend_q & line_ie));
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      flags_q <= '0;
      pend_q  <= 1'b0;
      int_l_q <= 1'b1;
    end else begin
      flags_q <= flags_d;
      pend_q  <= pend_d;
      int_l_q <= int_l_d;
    end
  end

  assign stat_reg_out = pack_status(flags_q);
  assign line_pend    = pend_q;
  assign INT_L        = int_l_q;

endmodule

// File: doc/vdp_irq_ctrl.md
Name: vdp_irq_ctrl

Overview:
- Interrupt and status-flag stage of the VDP.
- Consumes scanline timing and the VDP register values.
- Maintains the frame (VBlank) flag, the line-interrupt down-counter and the sprite flags.
- Drives the status byte read through the control port (0xBF) and the Z80 INT_L line.
- Fills the interrupt-register slot in vdp_top.

Parameters:
ACTIVE_LINES, 192, number of active display lines; frame flag sets on line_tick with line_num == ACTIVE_LINES
TOTAL_LINES, 262, scanlines per frame; line_num range is 0..TOTAL_LINES-1
LINE_W, 9, width of line_num

Ports:
clk  in  1  VDP I/O clock (clk_4 domain)
rst_L  in  1  asynchronous active-low reset
line_tick  in  1  one-cycle pulse at start of each scanline, synchronised to clk
line_num  in  LINE_W  scanline index valid when line_tick=1
line_ie  in  1  reg0 bit4, line interrupt enable
frame_ie  in  1  reg1 bit5, frame interrupt enable
line_reload  in  8  reg10, line counter reload value
spr_ovf  in  1  one-cycle pulse: sprite overflow detected
spr_col  in  1  one-cycle pulse: sprite collision detected
stat_rd  in  1  one-cycle pulse: CPU read of control port completed (MODE & ~CSR_L trailing edge)
stat_reg_out  out  8  {F, OVR, COL, 5'b0}
line_pend  out  1  line interrupt pending flag (debug/visibility)
INT_L  out  1  active-low interrupt request to Z80

Behaviour:
- Reset (async, rst_L=0):
  - F=OVR=COL=0, line_pend=0, counter=8'hFF.
  - INT_L=1, stat_reg_out=8'h00.
- Line counter (8-bit, updated only on line_tick):
  - line_num <= ACTIVE_LINES:
    - counter==0 -> counter=line_reload, line_pend=1.
    - otherwise counter=counter-1.
  - line_num > ACTIVE_LINES -> counter=line_reload; line_pend unchanged.
  - Wrap: counter never underflows; 0 always reloads.
- Frame flag: line_tick with line_num==ACTIVE_LINES -> F=1 in the next cycle.
- Sprite flags:
  - spr_ovf -> OVR=1.
  - spr_col -> COL=1.
- All flags are sticky until cleared.
- Status read: stat_reg_out is combinational from the flag registers, so the CPU sees the value held during the read.
- Clearing: on stat_rd, F, OVR, COL and line_pend all clear the following cycle.
- Simultaneous stat_rd and a set event in the same cycle: set wins for that flag; other flags clear.
- INT_L is registered: INT_L <= ~((F & frame_ie) | (line_pend & line_ie)).
  - Latency is one cycle after the flag register changes, i.e. two cycles after line_tick.
- Disabling an enable while a flag is pending:
  - INT_L deasserts next cycle; the flag is kept.
  - Re-enabling reasserts INT_L (level-triggered, matches Z80 IM1).
- line_tick while line_num >= TOTAL_LINES: ignored entirely.
- Reset mid-frame: the counter does not resume until the next line_tick after release; first active line behaves per the counter rules from 8'hFF (reload occurs on first post-active line).

Optional Feature:
- VDP_IRQ_VECTOR_EN: interrupt-acknowledge response.
- Defined:
  - Adds inputs M1_L and IORQ_L, and outputs vec_out[7:0] and vec_oe.
  - When ~M1_L & ~IORQ_L & ~INT_L: vec_oe=1 and vec_out=8'hFF (RST 38h), combinational.
  - line_pend clears on the rising edge of the acknowledge, i.e. the first cycle where M1_L|IORQ_L returns high after an acknowledge.
  - F still clears only on stat_rd.
- Undefined: ports absent; acknowledge has no effect on flags.

Decomposition:
- vdp_pkg holds:
  - status bit indices: STAT_F=7, STAT_OVR=6, STAT_COL=5.
  - register indices: REG_MODE1=0, REG_MODE2=1, REG_LINECNT=10.
  - enable bit positions: LINE_IE_BIT=4, FRAME_IE_BIT=5.
  - default ACTIVE_LINES/TOTAL_LINES.
- Sub-module vdp_line_counter: 8-bit reload/decrement counter.
  - Inputs: tick, active, reload value.
  - Output: one-cycle underflow pulse, which feeds line_pend set logic.

Test Plan:
- Reset check: rst_L=0 mid-frame with F=1 -> immediately INT_L=1, stat_reg_out=8'h00; after release no flag sets until the next qualifying line_tick.
- Line interrupt, line_reload=8'd3, line_ie=1, ticks on lines 193..261 then 0..7:
  - line_pend sets at lines 3 and 7.
  - INT_L falls 2 cycles after the tick of line 3.
  - stat_rd clears it, and INT_L=1 one cycle after line_pend clears.
- Frame interrupt, frame_ie=1:
  - tick with line_num=192 -> stat_reg_out=8'h80 the next cycle, INT_L=0 one cycle later.
  - stat_rd -> stat_reg_out=8'h00, then INT_L=1 one cycle later.
- Set/clear race: stat_rd in the same cycle as spr_col with OVR=1 -> next cycle stat_reg_out=8'h20.
- Enable masking: F=1 with frame_ie=0 -> INT_L stays 1; raise frame_ie -> INT_L=0 after 1 cycle; stat_reg_out still 8'h80.
- With VDP_IRQ_VECTOR_EN: pending line interrupt, then M1_L=IORQ_L=0 for 2 cycles -> vec_oe=1, vec_out=8'hFF; after release line_pend=0 and INT_L=1 (given F=0).
